// File: rtl/scanner_channel_pkg.sv
// Shared types and helpers for the scanner channel.
//   state_e : FSM encoding, also driven out on the 3-bit state port.
//   pct_of  : fill level in whole tenths, floor(count*10/depth).
package scanner_channel_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StStandby  = 3'd1,
    StScanning = 3'd2,
    StIdle     = 3'd3,
    StTransfer = 3'd4,
    StFlush    = 3'd5
  } state_e;

  // Truncating division, no rounding; count <= depth keeps the result in 0..10.
  function automatic logic [3:0] pct_of(input int unsigned count, input int unsigned depth);
    int unsigned pct;
    pct = (count * 10) / depth;
    return pct[3:0];
  endfunction

endpackage

// File: rtl/scanner_channel_buffer.sv
// Sample buffer for one scanner channel: circular RAM with read/write pointers and an
// occupancy count. The RAM contents are never reset; only pointers and count are.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop all contents (pointers and count to zero)
//   wr_en      : store wr_data at the write pointer
//   rd_en      : pop the entry at the read pointer
//   rd_data    : oldest buffered sample
//   count      : entries held, 0..DEPTH
module scanner_channel_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]     count_q;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (wr_en && !rd_en) begin
        count_q <= count_q + AW'(1);
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - AW'(1);
      end
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/scanner_channel.sv
// Scanner channel: control FSM around a sample buffer, with fill progress in tenths and
// one-cycle threshold-crossing pulses used to hand off to a peer channel.
//   clk, reset                          : clock, synchronous active-high reset
//   power_on, go_standby, start_scan,
//   start_transfer, flush               : control inputs (see FSM below)
//   in_valid/in_ready/in_data           : sample input stream, accepted while SCANNING
//   out_valid/out_ready/out_data        : transfer stream, oldest sample first, while TRANSFER
//   state                               : current FSM state
//   progress                            : floor(count*10/DEPTH)
//   ready_to_transfer                   : SCANNING and progress >= READY_PCT
//   other_standby/other_start/other_flush : crossing pulses for the peer channel
module scanner_channel
  import scanner_channel_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned READY_PCT   = 5,
  parameter int unsigned STANDBY_PCT = 8,
  parameter int unsigned START_PCT   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              power_on,
  input  logic              go_standby,
  input  logic              start_scan,
  input  logic              start_transfer,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [2:0]        state,
  output logic [3:0]        progress,
  output logic              ready_to_transfer,
  output logic              other_standby,
  output logic              other_start,
  output logic              other_flush
);

  localparam int unsigned AW         = $clog2(DEPTH + 1);
  localparam logic [3:0]  ReadyPct   = 4'(READY_PCT);
  localparam logic [3:0]  StandbyPct = 4'(STANDBY_PCT);
  localparam logic [3:0]  StartPct   = 4'(START_PCT);

  state_e        state_q;
  logic [3:0]    prev_progress_q;
  logic          fill_q;
  logic [AW-1:0] count;
  logic          wr_en, rd_en, clear, last_write, pulse_en;

  assign in_ready   = (state_q == StScanning) && (count < AW'(DEPTH));
  assign out_valid  = (state_q == StTransfer) && (count != '0);
  assign wr_en      = in_valid && in_ready;
  // A flush aborts the transfer, so a pop offered in the same cycle is not taken.
  assign rd_en      = out_valid && out_ready && !flush;
  assign last_write = wr_en && (count == AW'(DEPTH - 1));

  assign clear = ((state_q == StStandby) && start_scan) ||
                 ((state_q == StIdle) && !start_transfer && !flush && go_standby) ||
                 (state_q == StFlush);

  scanner_channel_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_data (out_data),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StOff;
      prev_progress_q <= '0;
      fill_q          <= 1'b0;
    end else begin
      prev_progress_q <= progress;
      fill_q          <= last_write;
      unique case (state_q)
        StOff: begin
          if (power_on || go_standby) state_q <= StStandby;
        end
        StStandby: begin
          if (start_scan) state_q <= StScanning;
        end
        StScanning: begin
          if (last_write) state_q <= StIdle;
        end
        StIdle: begin
          if (start_transfer)  state_q <= StTransfer;
          else if (flush)      state_q <= StFlush;
          else if (go_standby) state_q <= StStandby;
        end
        StTransfer: begin
          if (flush)                                state_q <= StFlush;
          else if (rd_en && (count == AW'(1)))      state_q <= StStandby;
        end
        StFlush: begin
          state_q <= StStandby;
        end
        default: state_q <= StOff;
      endcase
    end
  end

  assign state    = state_q;
  assign progress = pct_of(32'(count), DEPTH);

  assign ready_to_transfer = (state_q == StScanning) && (progress >= ReadyPct);

  // The write that fills the buffer lands in the first IDLE cycle; keep crossings live
  // there too so thresholds between the last partial tenth and 10 still fire once per pass.
  assign pulse_en = (state_q == StScanning) || fill_q;

  assign other_flush   = pulse_en && (prev_progress_q < ReadyPct)   && (progress >= ReadyPct);
  assign other_standby = pulse_en && (prev_progress_q < StandbyPct) && (progress >= StandbyPct);
  assign other_start   = pulse_en && (prev_progress_q < StartPct)   && (progress >= StartPct);

endmodule

// File: tb/tb_scanner_channel.sv
module tb_scanner_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // floor(c*10/16), c = 0..16
  int prog16 [17] = '{0, 0, 1, 1, 2, 3, 3, 4, 5, 5, 6, 6, 7, 8, 8, 9, 10};

  // ---------------- main DEPTH=16 instance ----------------
  logic       reset, power_on, go_standby, start_scan, start_transfer, flush;
  logic       in_valid, in_ready, out_valid, out_ready, rtt;
  logic       o_standby, o_start, o_flush;
  logic [7:0] in_data, out_data;
  logic [2:0] state;
  logic [3:0] progress;

  scanner_channel dut (
    .clk (clk), .reset (reset), .power_on (power_on), .go_standby (go_standby),
    .start_scan (start_scan), .start_transfer (start_transfer), .flush (flush),
    .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
    .out_valid (out_valid), .out_data (out_data), .out_ready (out_ready),
    .state (state), .progress (progress), .ready_to_transfer (rtt),
    .other_standby (o_standby), .other_start (o_start), .other_flush (o_flush)
  );

  // ---------------- DEPTH=4 instance ----------------
  logic       q_power_on, q_start_scan, q_in_valid, q_in_ready, q_out_valid, q_rtt;
  logic       q_standby, q_start, q_flush;
  logic [7:0] q_in_data, q_out_data;
  logic [2:0] q_state;
  logic [3:0] q_progress;

  scanner_channel #(.DEPTH (4)) d4 (
    .clk (clk), .reset (reset), .power_on (q_power_on), .go_standby (1'b0),
    .start_scan (q_start_scan), .start_transfer (1'b0), .flush (1'b0),
    .in_valid (q_in_valid), .in_data (q_in_data), .in_ready (q_in_ready),
    .out_valid (q_out_valid), .out_data (q_out_data), .out_ready (1'b0),
    .state (q_state), .progress (q_progress), .ready_to_transfer (q_rtt),
    .other_standby (q_standby), .other_start (q_start), .other_flush (q_flush)
  );

  // ---------------- cross-wired pair A/B ----------------
  logic       a_power_on, a_kick, a_start_transfer, a_in_valid, a_out_ready;
  logic       b_start_transfer, b_in_valid, b_out_ready;
  logic       a_in_ready, a_out_valid, a_rtt, a_ostandby, a_ostart, a_oflush;
  logic       b_in_ready, b_out_valid, b_rtt, b_ostandby, b_ostart, b_oflush;
  logic       a_start_scan;
  logic [7:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic [2:0] a_state, b_state;
  logic [3:0] a_progress, b_progress;

  assign a_start_scan = b_ostart | a_kick;

  scanner_channel ua (
    .clk (clk), .reset (reset), .power_on (a_power_on), .go_standby (b_ostandby),
    .start_scan (a_start_scan), .start_transfer (a_start_transfer), .flush (b_oflush),
    .in_valid (a_in_valid), .in_data (a_in_data), .in_ready (a_in_ready),
    .out_valid (a_out_valid), .out_data (a_out_data), .out_ready (a_out_ready),
    .state (a_state), .progress (a_progress), .ready_to_transfer (a_rtt),
    .other_standby (a_ostandby), .other_start (a_ostart), .other_flush (a_oflush)
  );

  scanner_channel ub (
    .clk (clk), .reset (reset), .power_on (1'b0), .go_standby (a_ostandby),
    .start_scan (a_ostart), .start_transfer (b_start_transfer), .flush (a_oflush),
    .in_valid (b_in_valid), .in_data (b_in_data), .in_ready (b_in_ready),
    .out_valid (b_out_valid), .out_data (b_out_data), .out_ready (b_out_ready),
    .state (b_state), .progress (b_progress), .ready_to_transfer (b_rtt),
    .other_standby (b_ostandby), .other_start (b_ostart), .other_flush (b_oflush)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  logic [7:0] a_exp_q [$];
  int popped = 0;
  int a_popped = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_data: unexpected pop of %0d with empty scoreboard", out_data);
      end else begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
        popped++;
      end
    end
  end

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready && !b_oflush) begin
      if (a_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_out_data: unexpected pop of %0d with empty scoreboard", a_out_data);
      end else begin
        check("a_out_data", int'(a_out_data), int'(a_exp_q.pop_front()));
        a_popped++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; power_on = 0; go_standby = 0; start_scan = 0; start_transfer = 0; flush = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    q_power_on = 0; q_start_scan = 0; q_in_valid = 0; q_in_data = 0;
    a_power_on = 0; a_kick = 0; a_start_transfer = 0; a_in_valid = 0; a_in_data = 0;
    a_out_ready = 0; b_start_transfer = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    tick(); tick();
    check("reset_state", int'(state), 0);
    check("reset_progress", int'(progress), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    reset = 1'b0;

    // 1: reset mid-scan with count 7
    power_on = 1; tick();
    check("t1_standby", int'(state), 1);
    start_scan = 1; tick(); start_scan = 0;
    check("t1_scanning", int'(state), 2);
    check("t1_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 7; i++) wr(8'(i + 1));
    check("t1_progress7", int'(progress), 4);
    reset = 1; tick(); reset = 0;
    exp_q.delete();
    check("t1_state", int'(state), 0);
    check("t1_progress", int'(progress), 0);
    check("t1_out_valid", int'(out_valid), 0);
    check("t1_in_ready0", int'(in_ready), 0);
    check("t1_pulses", int'({o_standby, o_start, o_flush}), 0);

    // 2: full scan pass
    tick();
    check("t2_standby", int'(state), 1);
    start_scan = 1; tick(); start_scan = 0;
    for (int c = 1; c <= 16; c++) begin
      wr(8'(c * 37 + 5));
      check("t2_progress", int'(progress), prog16[c]);
      check("t2_state", int'(state), (c == 16) ? 3 : 2);
      check("t2_rtt", int'(rtt), (c >= 8 && c < 16) ? 1 : 0);
      check("t2_oflush", int'(o_flush), (c == 8) ? 1 : 0);
      check("t2_ostandby", int'(o_standby), (c == 13) ? 1 : 0);
      check("t2_ostart", int'(o_start), (c == 15) ? 1 : 0);
    end
    check("t2_in_ready_full", int'(in_ready), 0);

    // 3: transfer with throttled sink
    start_transfer = 1; tick(); start_transfer = 0;
    check("t3_transfer", int'(state), 4);
    check("t3_out_valid", int'(out_valid), 1);
    popped = 0;
    for (int k = 0; k < 80 && popped < 16; k++) begin
      out_ready = (k % 2 == 0);
      tick();
      check("t3_no_pulse", int'({o_standby, o_start, o_flush}), 0);
    end
    out_ready = 0;
    check("t3_popped", popped, 16);
    check("t3_state", int'(state), 1);
    check("t3_scoreboard_empty", exp_q.size(), 0);

    // 4: start_transfer beats flush in IDLE, then flush aborts TRANSFER at count 9
    start_scan = 1; tick(); start_scan = 0;
    for (int c = 1; c <= 16; c++) wr(8'(8'hC0 ^ c));
    check("t4_idle", int'(state), 3);
    start_transfer = 1; flush = 1; tick(); start_transfer = 0; flush = 0;
    check("t4_transfer", int'(state), 4);
    out_ready = 1;
    for (int k = 0; k < 7; k++) tick();
    out_ready = 0;
    check("t4_progress9", int'(progress), 5);
    check("t4_state_still", int'(state), 4);
    flush = 1; out_ready = 1; tick(); flush = 0; out_ready = 0;
    check("t4_flush", int'(state), 5);
    check("t4_progress_kept", int'(progress), 5);
    tick();
    exp_q.delete();
    check("t4_standby", int'(state), 1);
    check("t4_count0", int'(progress), 0);
    check("t4_out_valid", int'(out_valid), 0);

    // 5: DEPTH=4, skipped tenths
    q_power_on = 1; tick();
    q_start_scan = 1; tick(); q_start_scan = 0;
    check("t5_scanning", int'(q_state), 2);
    for (int c = 1; c <= 4; c++) begin
      q_in_data = 8'(c); q_in_valid = 1; tick(); q_in_valid = 0;
      check("t5_progress", int'(q_progress), (c == 1) ? 2 : (c == 2) ? 5 : (c == 3) ? 7 : 10);
      check("t5_oflush", int'(q_flush), (c == 2) ? 1 : 0);
      check("t5_ostandby", int'(q_standby), (c == 4) ? 1 : 0);
      check("t5_ostart", int'(q_start), (c == 4) ? 1 : 0);
    end
    check("t5_idle", int'(q_state), 3);
    tick();
    check("t5_quiet", int'({q_standby, q_start, q_flush}), 0);

    // 6: ping-pong pair
    a_power_on = 1; tick();
    a_kick = 1; tick(); a_kick = 0;
    check("t6_a_scan", int'(a_state), 2);
    check("t6_b_off", int'(b_state), 0);
    for (int c = 1; c <= 16; c++) begin
      a_in_data = 8'(c * 11); a_in_valid = 1; a_exp_q.push_back(a_in_data);
      tick(); a_in_valid = 0;
      check("t6_b_state", int'(b_state), (c <= 13) ? 0 : (c <= 15) ? 1 : 2);
    end
    check("t6_a_idle", int'(a_state), 3);
    a_start_transfer = 1; tick(); a_start_transfer = 0;
    check("t6_a_transfer", int'(a_state), 4);
    a_popped = 0;
    for (int k = 0; k < 40 && a_popped < 16; k++) begin
      a_out_ready = 1;
      b_in_valid = (k < 5); b_in_data = 8'(k);
      tick();
    end
    a_out_ready = 0; b_in_valid = 0;
    check("t6_a_popped", a_popped, 16);
    check("t6_a_standby", int'(a_state), 1);
    check("t6_b_scan", int'(b_state), 2);
    check("t6_b_progress5", int'(b_progress), 3);
    for (int c = 6; c <= 15; c++) begin
      b_in_valid = 1; b_in_data = 8'(c); tick(); b_in_valid = 0;
      check("t6_b_oflush", int'(b_oflush), (c == 8) ? 1 : 0);
      check("t6_a_waits", int'(a_state), 1);
    end
    check("t6_b_ostart", int'(b_ostart), 1);
    tick();
    check("t6_a_rescan", int'(a_state), 2);
    check("t6_a_count0", int'(a_progress), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
